inst_fetch: RTL

IF-stage fetch engine, directly downstream of the PC register and upstream of the IF/ID pipeline register. It takes the current PC and chip-enable and runs one instruction-bus transaction per PC on an SRAM-like split address/data handshake. It holds the returned instruction until IF/ID accepts it, and raises a stall request to the pipeline controller while a fetch is in flight. It also discards responses made stale by a flush and flags misaligned PCs (AdEL) without issuing a bus access.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared encodings for the IF-stage fetch engine.
//   fetch_state_e : FSM state encoding (IDLE/REQ/WAIT/HOLD)
//   NopInst       : default instruction word when nothing valid is held
//   ExcAdEL       : exception code for a misaligned fetch address
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NopInst = 32'h0000_0000;
  localparam logic [4:0]  ExcAdEL = 5'h04;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: IF-stage fetch engine between the PC register and IF/ID.
// Runs one split address/data bus transaction per PC, holds the returned
// instruction until IF/ID takes it, drops responses made stale by a flush,
// and flags misaligned PCs (AdEL) without touching the bus.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc_i, ce_i             PC and fetch enable from the PC register
//   stall[5:0], flush      pipeline controls (stall[0] = IF hold)
//   inst_req/inst_addr     bus request channel (addr_ok handshake)
//   inst_addr_ok           slave accepted the request
//   inst_data_ok/rdata     bus response channel
//   stallreq_if            fetch in progress, controller must hold PC
//   if_pc/if_inst/if_valid/if_adel  held result to IF/ID
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        stallreq_if,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic         if_valid_q, if_valid_d;
  logic         if_adel_q, if_adel_d;

  // Only stall[0] concerns the fetch stage.
  logic unused_stall_hi;
  assign unused_stall_hi = ^stall[5:1];

  assign inst_addr = pc_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    if_adel_d   = if_adel_q;
    inst_req    = 1'b0;
    stallreq_if = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (ce_i) state_d = FETCH_REQ;
      end

      FETCH_REQ: begin
        if (!ce_i) begin
          state_d    = FETCH_IDLE;
          if_valid_d = 1'b0;
          if_adel_d  = 1'b0;
          if_inst_d  = NOP_INST;
        end else begin
          // PC must not advance until a result is held, even for AdEL.
          stallreq_if = 1'b1;
          if (pc_misaligned(pc_i)) begin
            // A flushed PC is about to be replaced; don't fault on it.
            if (!flush) begin
              state_d    = FETCH_HOLD;
              if_pc_d    = pc_i;
              if_inst_d  = NOP_INST;
              if_adel_d  = 1'b1;
              if_valid_d = 1'b1;
            end
          end else begin
            inst_req = 1'b1;
            if (inst_addr_ok) begin
              state_d   = FETCH_WAIT;
              pc_d      = pc_i;
              // Request accepted on the flush edge: its data is stale.
              discard_d = flush;
            end
          end
        end
      end

      FETCH_WAIT: begin
        stallreq_if = 1'b1;
        if (inst_data_ok) begin
          discard_d = 1'b0;
          if (discard_q || flush || !ce_i) begin
            state_d = ce_i ? FETCH_REQ : FETCH_IDLE;
          end else begin
            state_d    = FETCH_HOLD;
            if_inst_d  = inst_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if_adel_d  = 1'b0;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end

      FETCH_HOLD: begin
        if (!ce_i) begin
          state_d    = FETCH_IDLE;
          if_valid_d = 1'b0;
          if_adel_d  = 1'b0;
          if_inst_d  = NOP_INST;
        end else if (flush || !stall[0]) begin
          state_d    = FETCH_REQ;
          if_valid_d = 1'b0;
          if_adel_d  = 1'b0;
          if_inst_d  = NOP_INST;
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= 32'h0;
      discard_q  <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
      if_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      if_adel_q  <= if_adel_d;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;
  assign if_adel  = if_adel_q;

endmodule
